// File: rtl/ccc_clken_rst_seq.sv
// ccc_clken_rst_seq: PLL lock qualifier, staggered domain reset release and per-channel clock-enable dividers
module ccc_clken_rst_seq #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int LOCK_SYNC   = 2,
  parameter int LOCK_STABLE = 1024,
  parameter int STAGGER     = 16
) (
  input  logic                    CLK0,
  input  logic                    RESET_N,
  input  logic                    LOCK,
  input  logic [NUM_CH*DIV_W-1:0] DIV,
  input  logic                    CLR_LOST,
  output logic                    LOCKED,
  output logic [NUM_CH-1:0]       RST_N_OUT,
  output logic [NUM_CH-1:0]       CLKEN_OUT,
  output logic                    LOCK_LOST
);
  localparam int CMAX = LOCK_STABLE > STAGGER ? LOCK_STABLE : STAGGER;
  localparam int CW = $clog2(CMAX + 1);
  typedef enum logic [1:0] {WAIT_LOCK, STABLE, RELEASE, RUN} state_t;
  state_t state, state_n;
  logic [LOCK_SYNC-1:0] sync;
  logic [CW-1:0] cnt, cnt_n;
  logic lock_s, locked_n, lost_n, lost_set;
  logic [NUM_CH-1:0] rst_n_n, rst_step;
  assign lock_s = sync[LOCK_SYNC-1];
  always_ff @(posedge CLK0)
    if (!RESET_N) begin
      sync      <= '0;
      state     <= WAIT_LOCK;
      cnt       <= '0;
      LOCKED    <= 1'b0;
      RST_N_OUT <= '0;
      LOCK_LOST <= 1'b0;
    end else begin
      sync      <= {sync[LOCK_SYNC-2:0], LOCK};
      state     <= state_n;
      cnt       <= cnt_n;
      LOCKED    <= locked_n;
      RST_N_OUT <= rst_n_n;
      LOCK_LOST <= lost_n;
    end
  // one counter serves both the stability window and the stagger interval
  always_comb begin
    rst_step = (RST_N_OUT << 1) | NUM_CH'(1);
    state_n  = state;
    cnt_n    = cnt;
    locked_n = LOCKED;
    rst_n_n  = RST_N_OUT;
    lost_set = 1'b0;
    case (state)
      WAIT_LOCK: begin
        cnt_n = '0;
        if (lock_s) state_n = STABLE;
      end
      STABLE:
        if (!lock_s) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt == CW'(LOCK_STABLE - 1)) begin
          locked_n = 1'b1;
          state_n  = RELEASE;
          cnt_n    = '0;
        end else cnt_n = cnt + 1'b1;
      RELEASE:
        if (!lock_s) lost_set = 1'b1;
        else if (cnt == CW'(STAGGER - 1)) begin
          cnt_n   = '0;
          rst_n_n = rst_step;
          if (rst_step[NUM_CH-1]) state_n = RUN;
        end else cnt_n = cnt + 1'b1;
      default: lost_set = !lock_s;
    endcase
    if (lost_set) begin
      state_n  = WAIT_LOCK;
      cnt_n    = '0;
      locked_n = 1'b0;
      rst_n_n  = '0;
    end
    lost_n = lost_set | (LOCK_LOST & ~CLR_LOST);
  end
  for (genvar k = 0; k < NUM_CH; k++) begin : g_div
    logic [DIV_W-1:0] c, d, c_n, d_n;
    logic en;
    // enable is registered from next-state so it lines up with the cycle the counter hits d-1
    always_comb begin
      c_n = (d <= DIV_W'(1) || c == d - 1'b1) ? '0 : c + 1'b1;
      d_n = c_n == '0 ? DIV[k*DIV_W +: DIV_W] : d;
    end
    always_ff @(posedge CLK0)
      if (!RESET_N || !rst_n_n[k]) begin
        c  <= '0;
        d  <= '0;
        en <= 1'b0;
      end else begin
        c  <= c_n;
        d  <= d_n;
        en <= (d_n <= DIV_W'(1)) || (c_n == d_n - 1'b1);
      end
    assign CLKEN_OUT[k] = en;
  end
endmodule

// File: tb/tb_ccc_clken_rst_seq.sv
// tb_ccc_clken_rst_seq: scoreboard bench; timed expectations queued per scenario and checked on the falling edge
module tb_ccc_clken_rst_seq;
  localparam int NC = 2;
  localparam int DW = 4;
  logic CLK0 = 1'b0, RESET_N = 1'b0, LOCK = 1'b0, CLR_LOST = 1'b0;
  logic [NC*DW-1:0] DIV = '0;
  logic LOCKED, LOCK_LOST;
  logic [NC-1:0] RST_N_OUT, CLKEN_OUT;
  int cyc = 0, b = 0, n_chk = 0, n_pass = 0;
  typedef struct {int cyc; string tag; int sel; logic [7:0] val;} exp_t;
  exp_t q[$];
  ccc_clken_rst_seq #(.NUM_CH(NC), .DIV_W(DW), .LOCK_SYNC(2), .LOCK_STABLE(8), .STAGGER(4)) dut (
    .CLK0(CLK0), .RESET_N(RESET_N), .LOCK(LOCK), .DIV(DIV), .CLR_LOST(CLR_LOST),
    .LOCKED(LOCKED), .RST_N_OUT(RST_N_OUT), .CLKEN_OUT(CLKEN_OUT), .LOCK_LOST(LOCK_LOST)
  );
  always #5 CLK0 = ~CLK0;
  always @(posedge CLK0) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask
  function automatic logic [7:0] obs(input int sel);
    case (sel)
      0: return 8'(LOCKED);
      1: return 8'(LOCK_LOST);
      2: return 8'(RST_N_OUT);
      3: return 8'(CLKEN_OUT);
      4: return 8'(CLKEN_OUT[0]);
      default: return 8'(CLKEN_OUT[1]);
    endcase
  endfunction
  task automatic push_exp(input int r, input string tag, input int sel, input logic [7:0] v);
    q.push_back('{b + r, $sformatf("%s@%0d", tag, r), sel, v});
  endtask
  task automatic at(input int t);
    while (cyc < t) begin
      @(posedge CLK0);
      #1;
    end
  endtask
  task automatic do_reset();
    LOCK = 1'b0;
    CLR_LOST = 1'b0;
    RESET_N = 1'b0;
    b = cyc + 1;
    at(b);
    RESET_N = 1'b1;
    push_exp(0, "rst_locked", 0, 0);
    push_exp(0, "rst_lost", 1, 0);
    push_exp(0, "rst_rstn", 2, 0);
    push_exp(0, "rst_clken", 3, 0);
  endtask
  always @(negedge CLK0)
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].cyc == cyc) begin
        check(q[i].tag, obs(q[i].sel), q[i].val);
        q.delete(i);
      end
  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    DIV = {4'd1, 4'd3};
    do_reset();
    push_exp(19, "s1_locked", 0, 0);
    push_exp(20, "s1_locked", 0, 1);
    push_exp(23, "s1_rstn", 2, 0);
    push_exp(24, "s1_rstn", 2, 1);
    push_exp(27, "s1_rstn", 2, 1);
    push_exp(28, "s1_rstn", 2, 3);
    push_exp(30, "s1_lost", 1, 0);
    for (int r = 20; r <= 45; r++)
      push_exp(r, "s3_clken", 3, {6'd0, r >= 28, r == 26 || r == 29 || r == 32 || r == 37 || r == 42});
    push_exp(52, "s4_locked", 0, 1);
    push_exp(52, "s4_rstn", 2, 3);
    push_exp(53, "s4_locked", 0, 0);
    push_exp(53, "s4_rstn", 2, 0);
    push_exp(53, "s4_clken", 3, 0);
    push_exp(53, "s4_lost", 1, 1);
    push_exp(61, "s4_relock", 0, 0);
    push_exp(62, "s4_relock", 0, 1);
    push_exp(66, "s4_rstn", 2, 1);
    push_exp(70, "s4_rstn", 2, 3);
    push_exp(75, "s4_lost", 1, 1);
    push_exp(82, "s4_lost", 1, 1);
    push_exp(83, "s4_setwins", 1, 1);
    push_exp(84, "s4_setwins", 1, 1);
    push_exp(90, "s4_lost", 1, 1);
    push_exp(91, "s4_clr", 1, 0);
    push_exp(92, "s4_relock2", 0, 1);
    at(b + 9);  LOCK = 1'b1;
    at(b + 30); DIV[3:0] = 4'd5;
    at(b + 50); LOCK = 1'b0;
    at(b + 51); LOCK = 1'b1;
    at(b + 80); LOCK = 1'b0;
    at(b + 81); LOCK = 1'b1;
    at(b + 82); CLR_LOST = 1'b1;
    at(b + 83); CLR_LOST = 1'b0;
    at(b + 90); CLR_LOST = 1'b1;
    at(b + 91); CLR_LOST = 1'b0;
    at(b + 95);
    DIV = {4'd1, 4'd0};
    do_reset();
    push_exp(20, "s2_locked", 0, 0);
    push_exp(29, "s2_locked", 0, 0);
    push_exp(30, "s2_locked", 0, 1);
    push_exp(30, "s2_lost", 1, 0);
    push_exp(34, "s5_rstn", 2, 1);
    push_exp(35, "s5_rstn", 2, 1);
    push_exp(35, "s5_locked", 0, 1);
    push_exp(35, "s5_clken", 3, 1);
    push_exp(36, "s5_locked", 0, 0);
    push_exp(36, "s5_rstn", 2, 0);
    push_exp(36, "s5_clken", 3, 0);
    push_exp(36, "s5_lost", 1, 0);
    push_exp(38, "s5_rstn", 2, 0);
    push_exp(46, "s5_locked", 0, 0);
    push_exp(47, "s5_locked", 0, 1);
    push_exp(51, "s5_rstn", 2, 1);
    push_exp(55, "s5_rstn", 2, 3);
    at(b + 9);  LOCK = 1'b1;
    at(b + 14); LOCK = 1'b0;
    at(b + 19); LOCK = 1'b1;
    at(b + 35); RESET_N = 1'b0;
    at(b + 36); RESET_N = 1'b1;
    at(b + 60);
    DIV = {4'd0, 4'd15};
    do_reset();
    for (int r = 20; r <= 75; r++) begin
      push_exp(r, "s6_div15", 4, 8'(r >= 24 && (r - 24) % 15 == 14));
      push_exp(r, "s6_div0", 5, 8'(r >= 28));
    end
    at(b + 9); LOCK = 1'b1;
    at(b + 80);
    if (q.size() != 0) check("leftover", 8'(q.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
